// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receiver: FSM encoding, default parameters
// and the frame parity helper.
package ps2_pkg;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_FILTER_LEN = 8;
    localparam int DEF_TIMEOUT    = 5000;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Host-side bundle of the PS/2 receiver: raw PS/2 lines, read strobe and the
// FIFO head / status outputs.
interface ps2_rx_fifo_if;
    import ps2_pkg::*;

    logic              ps2_clk;
    logic              ps2_data;
    logic              rdn;
    logic [BYTE_W-1:0] data;
    logic              ready;
    logic              overflow;
    logic              parity_err;

    modport master (output ps2_clk, ps2_data, rdn,
                    input  data, ready, overflow, parity_err);
    modport slave  (input  ps2_clk, ps2_data, rdn,
                    output data, ready, overflow, parity_err);

endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizer, clock glitch filter, frame FSM with
// inactivity timeout, and a byte FIFO read through an active-low strobe.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a clock falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit and checking odd parity
//   STOP   | checking the stop bit, pushing the byte or flagging an error
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_rx_fifo_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]        clk_s, dat_s;
    logic              clk_f, clk_f_d;
    logic [FW-1:0]     flt_cnt;
    logic              bit_evt, ps2_bit;

    rx_state_t         state, nstate;
    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              par_ok;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              push, perr;

    logic              full, empty, pop;
    logic [BYTE_W-1:0] head;
    logic              ovf;

    // The filter level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s   <= 2'b11;
            dat_s   <= 2'b11;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= FW'(FILTER_LEN - 1);
        end else begin
            clk_s   <= {clk_s[0], bus.ps2_clk};
            dat_s   <= {dat_s[0], bus.ps2_data};
            clk_f_d <= clk_f;
            if (clk_s[1] == clk_f) begin
                flt_cnt <= FW'(FILTER_LEN - 1);
            end else if (flt_cnt == '0) begin
                clk_f   <= clk_s[1];
                flt_cnt <= FW'(FILTER_LEN - 1);
            end else begin
                flt_cnt <= flt_cnt - 1'b1;
            end
        end
    end

    assign bit_evt = clk_f_d & ~clk_f;
    assign ps2_bit = dat_s[1];
    assign tmo_hit = (state != IDLE) && !bit_evt && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        push   = 1'b0;
        perr   = 1'b0;
        case (state)
            IDLE:   if (bit_evt && !ps2_bit) nstate = DATA;
            DATA:   if (tmo_hit) nstate = IDLE;
                    else if (bit_evt && bit_cnt == 3'd0) nstate = PARITY;
            PARITY: if (tmo_hit) nstate = IDLE;
                    else if (bit_evt) nstate = STOP;
            STOP: begin
                if (tmo_hit) begin
                    nstate = IDLE;
                end else if (bit_evt) begin
                    nstate = IDLE;
                    if (ps2_bit && par_ok) push = 1'b1;
                    else                   perr = 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (bit_evt) begin
                case (state)
                    IDLE:    bit_cnt <= 3'd7;
                    DATA: begin
                        shreg   <= {ps2_bit, shreg[BYTE_W-1:1]};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    PARITY:  par_ok <= odd_parity_ok(shreg, ps2_bit);
                    default: ;
                endcase
            end
            // Reloaded on every bit event; reaching zero mid-frame aborts it.
            if (nstate == IDLE)    tmo_cnt <= '0;
            else if (bit_evt)      tmo_cnt <= TW'(TIMEOUT - 1);
            else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign pop = !bus.rdn && !empty;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // A simultaneous pop makes room, so only an unpaired push into full drops.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                 ovf <= 1'b0;
        else if (pop)              ovf <= 1'b0;
        else if (push && full)     ovf <= 1'b1;
    end

    assign bus.data       = head;
    assign bus.ready      = !empty;
    assign bus.overflow   = ovf;
    assign bus.parity_err = perr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks
// the FIFO outputs against hand-computed values.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int HALF = 20;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   perr_cnt = 0;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.parity_err === 1'b1) perr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half-period.
    // rdy_at reports the first low-phase cycle at which ready was seen high.
    task automatic send_bit(input logic b, input bit glitch, input int pop_at, output int rdy_at);
        rdy_at = 0;
        bus.ps2_data = b;
        for (int i = 1; i <= HALF; i++) begin
            tick(1);
            if (glitch && i == 12) bus.ps2_clk = 1'b0;
            if (glitch && i == 13) bus.ps2_clk = 1'b1;
        end
        bus.ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            tick(1);
            if (rdy_at == 0 && bus.ready === 1'b1) rdy_at = i;
            if (glitch && i == 15) bus.ps2_clk = 1'b1;
            if (glitch && i == 16) bus.ps2_clk = 1'b0;
            if (pop_at != 0 && i == pop_at)     bus.rdn = 1'b0;
            if (pop_at != 0 && i == pop_at + 1) bus.rdn = 1'b1;
        end
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int pop_at, output int rdy_at);
        logic [10:0] bits;
        int r;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        r = 0;
        for (int k = 0; k < 11; k++) send_bit(bits[k], glitch, (k == 10) ? pop_at : 0, r);
        rdy_at = r;
        bus.ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
        check(tag, 32'(bus.data), 32'(exp));
        bus.rdn = 1'b0;
        tick(1);
        bus.rdn = 1'b1;
    endtask

    initial begin
        int r;
        int p0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rdn      = 1'b1;
        clrn         = 1'b0;
        tick(3);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        clrn = 1'b1;
        tick(5);

        // Valid 8'h1C: ready rises 11 cycles after the stop-bit clock falls
        // (2 sync + 8 filter samples + 1 push edge).
        p0 = perr_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 0, r);
        check("lat_1c", 32'(r), 32'd11);
        check("ready_1c", 32'(bus.ready), 32'd1);
        check("data_1c", 32'(bus.data), 32'h1C);
        check("perr_1c", 32'(perr_cnt - p0), 32'd0);
        bus.rdn = 1'b0;
        tick(1);
        bus.rdn = 1'b1;
        check("ready_after_pop_1c", 32'(bus.ready), 32'd0);

        // Bad parity and bad stop bit: one-cycle error pulse each, nothing queued.
        p0 = perr_cnt;
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 0, r);
        check("perr_f0", 32'(perr_cnt - p0), 32'd1);
        check("ready_f0", 32'(bus.ready), 32'd0);
        p0 = perr_cnt;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 0, r);
        check("perr_stop", 32'(perr_cnt - p0), 32'd1);
        check("ready_stop", 32'(bus.ready), 32'd0);

        // Read strobe on an empty FIFO is ignored.
        bus.rdn = 1'b0;
        tick(4);
        bus.rdn = 1'b1;
        check("underflow_ready", 32'(bus.ready), 32'd0);

        // Nine frames into an eight-entry FIFO.
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 1'b0, 1'b0, 0, r);
            if (k == 8) check("ovf_at_8", 32'(bus.overflow), 32'd0);
        end
        check("ovf_at_9", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            pop_check(8'(k), "fill_pop");
            if (k == 1) check("ovf_clear", 32'(bus.overflow), 32'd0);
        end
        check("fill_empty", 32'(bus.ready), 32'd0);

        // Single-cycle glitches on both clock phases of every bit.
        p0 = perr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, r);
        check("glitch_perr", 32'(perr_cnt - p0), 32'd0);
        pop_check(8'h5A, "glitch_5a");
        check("glitch_empty", 32'(bus.ready), 32'd0);

        // Partial frame abandoned by the timeout.
        p0 = perr_cnt;
        send_bit(1'b0, 1'b0, 0, r);
        send_bit(1'b1, 1'b0, 0, r);
        send_bit(1'b0, 1'b0, 0, r);
        send_bit(1'b1, 1'b0, 0, r);
        send_bit(1'b1, 1'b0, 0, r);
        bus.ps2_data = 1'b1;
        tick(6000);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0, 0, r);
        check("tmo_perr", 32'(perr_cnt - p0), 32'd0);
        pop_check(8'h29, "tmo_29");
        check("tmo_empty", 32'(bus.ready), 32'd0);

        // Reset in the middle of a frame.
        send_bit(1'b0, 1'b0, 0, r);
        send_bit(1'b1, 1'b0, 0, r);
        send_bit(1'b1, 1'b0, 0, r);
        send_bit(1'b0, 1'b0, 0, r);
        bus.ps2_data = 1'b1;
        clrn = 1'b0;
        tick(2);
        check("midrst_ready", 32'(bus.ready), 32'd0);
        clrn = 1'b1;
        tick(5);
        send_frame(8'h76, 1'b0, 1'b0, 1'b0, 0, r);
        pop_check(8'h76, "midrst_76");
        check("midrst_empty", 32'(bus.ready), 32'd0);

        // Push and pop on the same edge while full: both succeed, no overflow.
        for (int k = 0; k < 8; k++) send_frame(8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 0, r);
        send_frame(8'h18, 1'b0, 1'b0, 1'b0, 10, r);
        check("full_pp_ovf", 32'(bus.overflow), 32'd0);
        for (int k = 1; k <= 8; k++) pop_check(8'(8'h10 + k), "full_pp_pop");
        check("full_pp_empty", 32'(bus.ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
